// File: rtl/audio_event_scheduler_pkg.sv
// ============================================================================
// Module      : audio_event_scheduler_pkg
// Description : Shared track codes, priority order and scheduler state codes.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package audio_event_scheduler_pkg;

    localparam int c_NUM_TRACKS = 4;

    typedef enum logic [1:0] {
        TRK_START   = 2'd0,
        TRK_HURT    = 2'd1,
        TRK_OVER    = 2'd2,
        TRK_RESTART = 2'd3
    } track_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_PLAY  = 3'd2,
        ST_ABORT = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    // Priority rank, larger wins: OVER > RESTART > HURT > START.
    function automatic logic [1:0] track_rank(input track_e t);
        case (t)
            TRK_OVER:    return 2'd3;
            TRK_RESTART: return 2'd2;
            TRK_HURT:    return 2'd1;
            default:     return 2'd0;
        endcase
    endfunction

    function automatic track_e pick_highest(input logic [c_NUM_TRACKS-1:0] pend);
        if (pend[TRK_OVER])         return TRK_OVER;
        else if (pend[TRK_RESTART]) return TRK_RESTART;
        else if (pend[TRK_HURT])    return TRK_HURT;
        else                        return TRK_START;
    endfunction

    function automatic logic higher_pending(input logic [c_NUM_TRACKS-1:0] pend,
                                            input track_e                  cur);
        logic found;
        found = 1'b0;
        for (int i = 0; i < c_NUM_TRACKS; i++) begin
            if (pend[i] && (track_rank(track_e'(i[1:0])) > track_rank(cur)))
                found = 1'b1;
        end
        return found;
    endfunction

endpackage

`default_nettype wire

// File: rtl/audio_event_scheduler_event_capture.sv
// ============================================================================
// Module      : event_capture
// Description : Rising-edge detection of game events into coalescing pending bits.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module event_capture
    import audio_event_scheduler_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [c_NUM_TRACKS-1:0] i_ev,
    input  logic [c_NUM_TRACKS-1:0] i_clr,
    output logic [c_NUM_TRACKS-1:0] o_pending
);

    logic [c_NUM_TRACKS-1:0] r_ev_prev;
    logic [c_NUM_TRACKS-1:0] r_pending;
    logic [c_NUM_TRACKS-1:0] w_rise;
    logic [c_NUM_TRACKS-1:0] w_clr;

    assign w_rise = i_ev & ~r_ev_prev;

    // A restart edge flushes queued START/HURT; a fresh edge still beats any clear.
    always_comb begin
        w_clr = i_clr;
        if (w_rise[TRK_RESTART]) begin
            w_clr[TRK_START] = 1'b1;
            w_clr[TRK_HURT]  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ev_prev <= '0;
            r_pending <= '0;
        end else begin
            r_ev_prev <= i_ev;
            r_pending <= (r_pending & ~w_clr) | w_rise;
        end
    end

    assign o_pending = r_pending;

endmodule

`default_nettype wire

// File: rtl/audio_event_scheduler.sv
// ============================================================================
// Module      : audio_event_scheduler
// Description : Prioritised MP3 track request FSM with abort, gap and timeout.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module audio_event_scheduler
    import audio_event_scheduler_pkg::*;
#(
    parameter int GAP_CYCLES     = 1000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_ev_start,
    input  logic       i_ev_hurt,
    input  logic       i_ev_over,
    input  logic       i_ev_restart,
    input  logic       i_play_ack,
    input  logic       i_play_done,
    output logic       o_play_req,
    output logic [1:0] o_track_id,
    output logic       o_play_abort,
    output logic       o_busy,
    output logic       o_error
);

    localparam int c_CNT_MAX_I = (GAP_CYCLES > TIMEOUT_CYCLES) ?
                                 ((GAP_CYCLES > 1) ? GAP_CYCLES : 1) :
                                 ((TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES : 1);
    localparam int c_CNT_W     = $clog2(c_CNT_MAX_I + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(c_CNT_MAX_I);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST =
        c_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [c_CNT_W-1:0] c_TO_LAST =
        c_CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [c_NUM_TRACKS-1:0] w_ev;
    logic [c_NUM_TRACKS-1:0] w_pending;
    logic [c_NUM_TRACKS-1:0] w_clr;
    track_e                  w_sel;
    logic [c_CNT_W-1:0]      w_cnt_inc;

    state_e             r_state;
    track_e             r_track;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_play_req;
    logic               r_abort;
    logic               r_busy;
    logic               r_error;

    assign w_ev = {i_ev_restart, i_ev_over, i_ev_hurt, i_ev_start};

    event_capture u_event_capture (
        .clk       (clk),
        .rst       (rst),
        .i_ev      (w_ev),
        .i_clr     (w_clr),
        .o_pending (w_pending)
    );

    assign w_sel     = pick_highest(w_pending);
    assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    // The selected bit is consumed in the same cycle the FSM leaves IDLE.
    always_comb begin
        w_clr = '0;
        if ((r_state == ST_IDLE) && (|w_pending))
            w_clr[w_sel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_track    <= TRK_START;
            r_cnt      <= '0;
            r_play_req <= 1'b0;
            r_abort    <= 1'b0;
            r_busy     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_abort <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|w_pending) begin
                        r_track    <= w_sel;
                        r_cnt      <= '0;
                        r_play_req <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (i_play_ack) begin
                        r_play_req <= 1'b0;
                        r_state    <= ST_PLAY;
                    end else if (r_cnt >= c_TO_LAST) begin
                        r_error    <= 1'b1;
                        r_play_req <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_PLAY: begin
                    // A finishing track is never aborted, even by a higher event.
                    if (i_play_done) begin
                        r_cnt   <= '0;
                        r_state <= ST_GAP;
                    end else if (higher_pending(w_pending, r_track)) begin
                        r_abort <= 1'b1;
                        r_state <= ST_ABORT;
                    end
                end
                ST_ABORT: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                ST_GAP: begin
                    if (r_cnt >= c_GAP_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_play_req <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_play_req   = r_play_req;
    assign o_track_id   = r_track;
    assign o_play_abort = r_abort;
    assign o_busy       = r_busy;
    assign o_error      = r_error;

endmodule

`default_nettype wire

// File: tb/tb_audio_event_scheduler.sv
// ============================================================================
// Module      : tb_audio_event_scheduler
// Description : Scoreboard bench for the audio event scheduler (gap 4, timeout 8).
// Revision    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_audio_event_scheduler;

    localparam int c_GAP = 4;
    localparam int c_TO  = 8;
    localparam int K_REQ   = 0;
    localparam int K_ABORT = 1;
    localparam int K_ERR   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ev_start = 1'b0, ev_hurt = 1'b0, ev_over = 1'b0, ev_restart = 1'b0;
    logic       play_ack = 1'b0, play_done = 1'b0;
    logic       o_play_req, o_play_abort, o_busy, o_error;
    logic [1:0] o_track_id;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int kind;
        int track;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    audio_event_scheduler #(
        .GAP_CYCLES     (c_GAP),
        .TIMEOUT_CYCLES (c_TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_ev_start   (ev_start),
        .i_ev_hurt    (ev_hurt),
        .i_ev_over    (ev_over),
        .i_ev_restart (ev_restart),
        .i_play_ack   (play_ack),
        .i_play_done  (play_done),
        .o_play_req   (o_play_req),
        .o_track_id   (o_track_id),
        .o_play_abort (o_play_abort),
        .o_busy       (o_busy),
        .o_error      (o_error)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic expect_ev(input int kind, input int track);
        exp_t e;
        e.kind  = kind;
        e.track = track;
        exp_q.push_back(e);
    endtask

    task automatic pulse_ack();
        play_ack = 1'b1;
        tick(1);
        play_ack = 1'b0;
    endtask

    task automatic pulse_done();
        play_done = 1'b1;
        tick(1);
        play_done = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (!o_play_req && n < 40) begin
            tick(1);
            n++;
        end
        check(name, int'(o_play_req), 1);
    endtask

    // Monitor: every request, abort pulse and error rise is matched against the queue.
    logic prev_req = 1'b0;
    logic prev_err = 1'b0;

    task automatic observe(input int kind, input int track);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL monitor: unexpected event kind %0d track %0d, queue empty", kind, track);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind == K_REQ && e.track != track)) begin
                errors++;
                $display("FAIL monitor: got kind %0d track %0d expected kind %0d track %0d",
                         kind, track, e.kind, e.track);
            end
        end
    endtask

    always @(negedge clk) begin
        if (o_play_req && !prev_req) observe(K_REQ, int'(o_track_id));
        if (o_play_abort)            observe(K_ABORT, 0);
        if (o_error && !prev_err)    observe(K_ERR, 0);
        prev_req = o_play_req;
        prev_err = o_error;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(3);
        check("rst_req",   int'(o_play_req),   0);
        check("rst_track", int'(o_track_id),   0);
        check("rst_abort", int'(o_play_abort), 0);
        check("rst_busy",  int'(o_busy),       0);
        check("rst_error", int'(o_error),      0);
        rst = 1'b0;
        tick(2);
        check("idle_busy", int'(o_busy), 0);

        // HURT latency and acknowledge
        expect_ev(K_REQ, 1);
        ev_hurt = 1'b1;
        tick(1);
        check("lat_n1_req", int'(o_play_req), 0);
        tick(1);
        check("lat_n2_req",   int'(o_play_req), 1);
        check("lat_track",    int'(o_track_id), 1);
        check("req_busy",     int'(o_busy),     1);
        tick(1);
        pulse_ack();
        check("ack_req_low", int'(o_play_req), 0);
        check("play_busy",   int'(o_busy),     1);

        // OVER preempts HURT: one abort pulse, then OVER without gap
        expect_ev(K_ABORT, 0);
        expect_ev(K_REQ, 2);
        ev_over = 1'b1;
        tick(2);
        check("abort_pulse", int'(o_play_abort), 1);
        tick(1);
        check("abort_one_cycle", int'(o_play_abort), 0);
        check("abort_no_req",    int'(o_play_req),   0);
        tick(1);
        check("over_req",   int'(o_play_req), 1);
        check("over_track", int'(o_track_id), 2);
        ev_hurt = 1'b0;
        ev_over = 1'b0;
        pulse_ack();

        // Lower-priority events wait for DONE plus the gap, HURT before START
        expect_ev(K_REQ, 1);
        expect_ev(K_REQ, 0);
        ev_start = 1'b1;
        tick(2);
        ev_hurt = 1'b1;
        tick(3);
        check("no_abort_lower", int'(o_play_abort), 0);
        check("still_playing",  int'(o_busy),       1);
        pulse_done();
        tick(3);
        check("gap_busy",   int'(o_busy),     1);
        check("gap_no_req", int'(o_play_req), 0);
        tick(1);
        check("gap_end_idle", int'(o_busy), 0);
        tick(1);
        check("hurt_after_gap",       int'(o_play_req), 1);
        check("hurt_after_gap_track", int'(o_track_id), 1);
        pulse_ack();
        pulse_done();
        wait_req("start_req");
        check("start_track", int'(o_track_id), 0);
        pulse_ack();
        pulse_done();
        tick(6);
        check("idle_after_start", int'(o_busy), 0);
        ev_start = 1'b0;
        ev_hurt  = 1'b0;
        tick(1);

        // Handshake timeout sets a sticky error
        expect_ev(K_REQ, 0);
        expect_ev(K_ERR, 0);
        ev_start = 1'b1;
        wait_req("to_req");
        tick(c_TO - 1);
        check("to_req_held", int'(o_play_req), 1);
        check("to_no_err",   int'(o_error),    0);
        tick(1);
        check("to_req_drop", int'(o_play_req), 0);
        check("to_err",      int'(o_error),    1);
        check("to_idle",     int'(o_busy),     0);
        pulse_ack();
        pulse_done();
        tick(3);
        check("err_sticky",     int'(o_error), 1);
        check("stray_ignored",  int'(o_busy),  0);
        ev_start = 1'b0;
        tick(1);

        // RESTART flushes pending START and HURT
        expect_ev(K_REQ, 2);
        expect_ev(K_REQ, 3);
        ev_over = 1'b1;
        wait_req("e_over_req");
        pulse_ack();
        ev_start = 1'b1;
        ev_hurt  = 1'b1;
        tick(2);
        ev_restart = 1'b1;
        tick(2);
        check("restart_no_abort", int'(o_play_abort), 0);
        pulse_done();
        wait_req("restart_req");
        check("restart_track", int'(o_track_id), 3);
        pulse_ack();
        pulse_done();
        tick(10);
        check("start_hurt_flushed", int'(o_busy), 0);
        ev_start   = 1'b0;
        ev_hurt    = 1'b0;
        ev_over    = 1'b0;
        ev_restart = 1'b0;
        tick(1);

        // Reset during PLAY; HURT held high through release yields one event
        expect_ev(K_REQ, 1);
        expect_ev(K_REQ, 1);
        ev_hurt = 1'b1;
        wait_req("f_req");
        pulse_ack();
        tick(2);
        rst = 1'b1;
        tick(1);
        check("rst_play_req",   int'(o_play_req),   0);
        check("rst_play_track", int'(o_track_id),   0);
        check("rst_play_abort", int'(o_play_abort), 0);
        check("rst_play_busy",  int'(o_busy),       0);
        check("rst_play_error", int'(o_error),      0);
        tick(1);
        rst = 1'b0;
        wait_req("held_through_reset");
        check("held_track", int'(o_track_id), 1);
        ev_hurt = 1'b0;
        pulse_ack();
        pulse_done();
        tick(8);
        check("final_idle",  int'(o_busy),  0);
        check("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
